// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and sizing helpers for the CCFF chain loader.
// Counters are sized to hold the value CHAIN_LEN itself.
package ccff_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    LOAD    = 3'd2,
    VERIFY  = 3'd3,
    DONE    = 3'd4
  } state_e;

  function automatic int num_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  function automatic int cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration word stream between the config source (master) and the loader (slave).
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();

  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);

endinterface

// File: rtl/ccff_chain_model.sv
// Behavioural stand-in for the fabric CCFF chain: position 0 drives the tail pin.
// A fault window inverts the tail for the fault_pos-th shift counted while fault_en is high.
module ccff_chain_model #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 prog_en,
  input  logic                 head,
  input  logic                 fault_en,
  input  logic [7:0]           fault_pos,
  output logic                 tail,
  output logic [CHAIN_LEN-1:0] contents
);

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [7:0]           pos_q, pos_d;

  always_comb begin
    chain_d = chain_q;
    pos_d   = 8'd0;
    if (prog_en) chain_d = {head, chain_q[CHAIN_LEN-1:1]};
    if (fault_en) pos_d = prog_en ? pos_q + 8'd1 : pos_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      pos_q   <= 8'd0;
    end else begin
      chain_q <= chain_d;
      pos_q   <= pos_d;
    end
  end

  assign tail     = chain_q[0] ^ (fault_en && (pos_q == fault_pos));
  assign contents = chain_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Collects config words into a shadow register, shifts them into the CCFF chain,
// then recirculates the chain once and flags any tail bit that differs from the shadow.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  ccff_chain_loader_if.slave  cfg,
  output logic                busy,
  output logic                done,
  output logic                verify_err,
  output logic                prog_en,
  output logic                ccff_head,
  input  logic                ccff_tail
);

  localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
  localparam int CNT_W     = cnt_w(CHAIN_LEN);
  localparam int IDX_W     = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic                 err_q, err_d;
  logic                 start_q, start_d;
  logic                 xfer;
  int                   idx;

  assign cfg.word_ready = (state_q == COLLECT);
  assign xfer           = cfg.word_valid & cfg.word_ready;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign prog_en        = (state_q == LOAD) || (state_q == VERIFY);
  assign verify_err     = err_q;

  // Verify recirculates the tail straight back into the head so the chain is restored.
  always_comb begin
    ccff_head = 1'b0;
    if (state_q == LOAD)   ccff_head = shadow_q[0];
    if (state_q == VERIFY) ccff_head = ccff_tail;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    idx      = 0;
    // The registered start adds one cycle between the start pulse and COLLECT.
    start_d  = start && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (start) err_d = 1'b0;
        if (start_q) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (xfer) begin
          for (int j = 0; j < WORD_W; j++) begin
            idx = int'(cnt_q) * WORD_W + j;
            if (idx < CHAIN_LEN) shadow_d[IDX_W'(idx)] = cfg.word_data[j];
          end
          if (cnt_q == LAST_WORD) begin
            state_d = LOAD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      LOAD, VERIFY: begin
        // Rotating the shadow keeps bit k at position 0 in shift cycle k of both phases.
        shadow_d = {shadow_q[0], shadow_q[CHAIN_LEN-1:1]};
        if (state_q == VERIFY && ccff_tail != shadow_q[0]) err_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = (state_q == LOAD) ? VERIFY : DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      // NOTE: the shadow register is reset like any flop; it is a plain register, not a RAM.
      shadow_q <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      start_q  <= start_d;
    end
  end

endmodule
